// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: multi-cycle MUL stall, load-use stall and branch flush.
// Optional stall-cycle performance counter enabled by macro HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
  parameter int unsigned MUL_LAT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ID_EX_MemRead_i,
  input  logic [4:0]  ID_EX_RTaddr_i,
  input  logic        ID_EX_Mul_i,
  input  logic [4:0]  IF_ID_RSaddr_i,
  input  logic [4:0]  IF_ID_RTaddr_i,
  input  logic        ID_Branch_i,
  output logic        PCWrite_o,
  output logic        IF_ID_Write_o,
  output logic        IF_ID_Flush_o,
  output logic        ID_EX_Write_o,
  output logic        ID_EX_Bubble_o,
  output logic        EX_MEM_Bubble_o,
  output logic        Mul_Start_o,
  output logic        Mul_Done_o,
  output logic [15:0] stall_cnt_o
);

  // state    | meaning
  // RUN      | normal issue; load-use / branch handling active
  // MUL_BUSY | multiplier occupying EX; mul_cnt counts remaining stall cycles
  typedef enum logic {RUN, MUL_BUSY} state_e;

  localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_LAT - 2);

  state_e     state_q, state_d;
  logic [3:0] mul_cnt_q, mul_cnt_d;
  logic       load_use;

  assign load_use = ID_EX_MemRead_i && (ID_EX_RTaddr_i != 5'd0) &&
                    ((ID_EX_RTaddr_i == IF_ID_RSaddr_i) || (ID_EX_RTaddr_i == IF_ID_RTaddr_i));

  always_comb begin
    state_d         = state_q;
    mul_cnt_d       = mul_cnt_q;
    PCWrite_o       = 1'b1;
    IF_ID_Write_o   = 1'b1;
    ID_EX_Write_o   = 1'b1;
    IF_ID_Flush_o   = 1'b0;
    ID_EX_Bubble_o  = 1'b0;
    EX_MEM_Bubble_o = 1'b0;
    Mul_Start_o     = 1'b0;
    Mul_Done_o      = 1'b0;
    if (rst_i) begin
      state_d   = RUN;
      mul_cnt_d = 4'd0;
    end else begin
      case (state_q)
        RUN: begin
          if (ID_EX_Mul_i) begin
            Mul_Start_o     = 1'b1;
            PCWrite_o       = 1'b0;
            IF_ID_Write_o   = 1'b0;
            ID_EX_Write_o   = 1'b0;
            EX_MEM_Bubble_o = 1'b1;
            state_d         = MUL_BUSY;
            mul_cnt_d       = MUL_CNT_INIT;
          end else if (load_use) begin
            PCWrite_o      = 1'b0;
            IF_ID_Write_o  = 1'b0;
            ID_EX_Bubble_o = 1'b1;
          end else if (ID_Branch_i) begin
            IF_ID_Flush_o = 1'b1;
          end
        end
        MUL_BUSY: begin
          if (mul_cnt_q != 4'd0) begin
            PCWrite_o       = 1'b0;
            IF_ID_Write_o   = 1'b0;
            ID_EX_Write_o   = 1'b0;
            EX_MEM_Bubble_o = 1'b1;
            mul_cnt_d       = mul_cnt_q - 4'd1;
          end else begin
            // ID advances this cycle, so a branch held during the stall resolves now
            Mul_Done_o    = 1'b1;
            IF_ID_Flush_o = ID_Branch_i;
            state_d       = RUN;
          end
        end
        default: begin
          state_d   = RUN;
          mul_cnt_d = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= RUN;
      mul_cnt_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      mul_cnt_q <= mul_cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!PCWrite_o && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) stall_cnt_q <= 16'd0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench for pipeline_hazard_ctrl (MUL_LAT=4 and MUL_LAT=2 instances).
module tb_pipeline_hazard_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       ID_EX_MemRead_i, ID_EX_Mul_i, ID_Branch_i;
  logic [4:0] ID_EX_RTaddr_i, IF_ID_RSaddr_i, IF_ID_RTaddr_i;

  logic        pcw1, ifw1, fl1, idw1, bub1, exb1, st1, dn1;
  logic        pcw2, ifw2, fl2, idw2, bub2, exb2, st2, dn2;
  logic [15:0] cnt1, cnt2;

  // {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Bubble, EX_MEM_Bubble, Mul_Start, Mul_Done}
  localparam logic [7:0] IDLE   = 8'b1101_0000;
  localparam logic [7:0] MSTART = 8'b0000_0110;
  localparam logic [7:0] MSTALL = 8'b0000_0100;
  localparam logic [7:0] MDONE  = 8'b1101_0001;
  localparam logic [7:0] LU     = 8'b0001_1000;
  localparam logic [7:0] BR     = 8'b1111_0000;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_q[$];
  string       tag_q[$];

  always #5 clk_i = ~clk_i;

  pipeline_hazard_ctrl #(.MUL_LAT(4)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ID_EX_MemRead_i(ID_EX_MemRead_i), .ID_EX_RTaddr_i(ID_EX_RTaddr_i),
    .ID_EX_Mul_i(ID_EX_Mul_i), .IF_ID_RSaddr_i(IF_ID_RSaddr_i),
    .IF_ID_RTaddr_i(IF_ID_RTaddr_i), .ID_Branch_i(ID_Branch_i),
    .PCWrite_o(pcw1), .IF_ID_Write_o(ifw1), .IF_ID_Flush_o(fl1),
    .ID_EX_Write_o(idw1), .ID_EX_Bubble_o(bub1), .EX_MEM_Bubble_o(exb1),
    .Mul_Start_o(st1), .Mul_Done_o(dn1), .stall_cnt_o(cnt1)
  );

  pipeline_hazard_ctrl #(.MUL_LAT(2)) u_dut2 (
    .clk_i(clk_i), .rst_i(rst_i),
    .ID_EX_MemRead_i(ID_EX_MemRead_i), .ID_EX_RTaddr_i(ID_EX_RTaddr_i),
    .ID_EX_Mul_i(ID_EX_Mul_i), .IF_ID_RSaddr_i(IF_ID_RSaddr_i),
    .IF_ID_RTaddr_i(IF_ID_RTaddr_i), .ID_Branch_i(ID_Branch_i),
    .PCWrite_o(pcw2), .IF_ID_Write_o(ifw2), .IF_ID_Flush_o(fl2),
    .ID_EX_Write_o(idw2), .ID_EX_Bubble_o(bub2), .EX_MEM_Bubble_o(exb2),
    .Mul_Start_o(st2), .Mul_Done_o(dn2), .stall_cnt_o(cnt2)
  );

  wire [15:0] obs_vec = {pcw1, ifw1, fl1, idw1, bub1, exb1, st1, dn1,
                         pcw2, ifw2, fl2, idw2, bub2, exb2, st2, dn2};

  task automatic check_outputs();
    logic [15:0] e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    n_tests++;
    assert (obs_vec === e) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", t, obs_vec, e);
    end
  endtask

  task automatic step(input string tag, input logic rst, input logic mul, input logic memrd,
                      input logic [4:0] rt_ex, input logic [4:0] rs_id, input logic [4:0] rt_id,
                      input logic br, input logic [7:0] e1, input logic [7:0] e2);
    @(negedge clk_i);
    rst_i = rst; ID_EX_Mul_i = mul; ID_EX_MemRead_i = memrd;
    ID_EX_RTaddr_i = rt_ex; IF_ID_RSaddr_i = rs_id; IF_ID_RTaddr_i = rt_id; ID_Branch_i = br;
    exp_q.push_back({e1, e2});
    tag_q.push_back(tag);
    #1;
    check_outputs();
  endtask

  task automatic check_cnt(input string tag, input logic [15:0] obs, input logic [15:0] e);
    n_tests++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, e);
    end
  endtask

  initial begin
    rst_i = 1'b1; ID_EX_Mul_i = 1'b0; ID_EX_MemRead_i = 1'b0; ID_Branch_i = 1'b0;
    ID_EX_RTaddr_i = 5'd0; IF_ID_RSaddr_i = 5'd0; IF_ID_RTaddr_i = 5'd0;

    // reset dominates every hazard input
    step("reset_outputs", 1, 1, 1, 5'd5, 5'd5, 5'd0, 1, IDLE, IDLE);
    check_cnt("reset_cnt", cnt1, 16'd0);
    step("idle",          0, 0, 0, 5'd0, 5'd0, 5'd0, 0, IDLE, IDLE);

    step("mul_start",     0, 1, 0, 5'd0, 5'd0, 5'd0, 0, MSTART, MSTART);
    step("mul_busy1",     0, 0, 0, 5'd0, 5'd0, 5'd0, 0, MSTALL, MDONE);
    step("mul_busy2",     0, 0, 0, 5'd0, 5'd0, 5'd0, 0, MSTALL, IDLE);
    step("mul_done",      0, 0, 0, 5'd0, 5'd0, 5'd0, 0, MDONE,  IDLE);
    step("b2b_start",     0, 1, 0, 5'd0, 5'd0, 5'd0, 0, MSTART, MSTART);
    step("b2b_busy1",     0, 0, 0, 5'd0, 5'd0, 5'd0, 0, MSTALL, MDONE);
    step("b2b_busy2",     0, 0, 0, 5'd0, 5'd0, 5'd0, 0, MSTALL, IDLE);
    step("b2b_done",      0, 0, 0, 5'd0, 5'd0, 5'd0, 0, MDONE,  IDLE);
    step("post_mul_idle", 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, IDLE,   IDLE);
    check_cnt("cnt_two_muls",  cnt1, CNT_EN ? 16'd6 : 16'd0);
    check_cnt("cnt2_two_muls", cnt2, CNT_EN ? 16'd2 : 16'd0);

    step("lu_rt_match",   0, 0, 1, 5'd5, 5'd1, 5'd5, 0, LU,   LU);
    step("lu_reg0",       0, 0, 1, 5'd0, 5'd0, 5'd0, 0, IDLE, IDLE);
    step("lu_rs_match",   0, 0, 1, 5'd7, 5'd7, 5'd2, 0, LU,   LU);
    step("lu_no_match",   0, 0, 1, 5'd7, 5'd3, 5'd4, 0, IDLE, IDLE);
    step("no_load",       0, 0, 0, 5'd5, 5'd5, 5'd5, 0, IDLE, IDLE);
    step("lu_over_br",    0, 0, 1, 5'd9, 5'd9, 5'd0, 1, LU,   LU);
    step("br_after_lu",   0, 0, 0, 5'd9, 5'd9, 5'd0, 1, BR,   BR);

    step("mul_over_all",  0, 1, 1, 5'd9, 5'd9, 5'd0, 1, MSTART, MSTART);
    step("prio_busy1",    0, 0, 0, 5'd0, 5'd0, 5'd0, 0, MSTALL, MDONE);
    step("prio_busy2",    0, 0, 0, 5'd0, 5'd0, 5'd0, 0, MSTALL, IDLE);
    step("prio_done",     0, 0, 0, 5'd0, 5'd0, 5'd0, 0, MDONE,  IDLE);
    step("prio_idle",     0, 0, 0, 5'd0, 5'd0, 5'd0, 0, IDLE,   IDLE);
    check_cnt("cnt_total",  cnt1, CNT_EN ? 16'd12 : 16'd0);
    check_cnt("cnt2_total", cnt2, CNT_EN ? 16'd6  : 16'd0);

    // reset in the second busy cycle of the MUL_LAT=4 sequence
    step("abort_start",   0, 1, 0, 5'd0, 5'd0, 5'd0, 0, MSTART, MSTART);
    step("abort_busy1",   0, 0, 0, 5'd0, 5'd0, 5'd0, 0, MSTALL, MDONE);
    step("abort_reset",   1, 0, 0, 5'd0, 5'd0, 5'd0, 0, IDLE,   IDLE);
    step("abort_after1",  0, 0, 0, 5'd0, 5'd0, 5'd0, 0, IDLE,   IDLE);
    check_cnt("cnt_after_reset", cnt1, 16'd0);
    step("abort_after2",  0, 0, 0, 5'd0, 5'd0, 5'd0, 0, IDLE,   IDLE);
    step("abort_after3",  0, 0, 0, 5'd0, 5'd0, 5'd0, 0, IDLE,   IDLE);
    step("after_abort_br",0, 0, 0, 5'd0, 5'd0, 5'd0, 1, BR,     BR);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
